// File: rtl/cpu_sdram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sdram_arb_pkg
// Brief    : Shared types and constants for the CPU SDRAM port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_sdram_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int SDRAM_ADDR_W = 26;
    localparam int TAG_W        = 9;
    localparam int DATA_W       = 32;
    localparam int STRB_W       = 4;

    localparam int REQ_DCACHE   = 0;
    localparam int REQ_ICACHE   = 1;
    localparam int REQ_DMA      = 2;

endpackage
`default_nettype wire

// File: rtl/cpu_sdram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sdram_arbiter_if
// Brief    : Requester-side and SDRAM-side buses of the arbiter; slave = arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_sdram_arbiter_if #(
    parameter int NUM_REQ = 3
);
    import cpu_sdram_arb_pkg::*;

    logic [NUM_REQ-1:0]                   req_request;
    logic [NUM_REQ-1:0]                   req_lock;
    logic [NUM_REQ-1:0]                   req_write;
    logic [NUM_REQ-1:0][SDRAM_ADDR_W-1:0] req_address;
    logic [NUM_REQ-1:0][STRB_W-1:0]       req_wstrb;
    logic [NUM_REQ-1:0][DATA_W-1:0]       req_wdata;
    logic [NUM_REQ-1:0]                   req_ready;
    logic [NUM_REQ-1:0]                   req_rvalid;
    logic [DATA_W-1:0]                    req_rdata;
    logic [TAG_W-1:0]                     req_rtag;

    logic                                 sdram_request;
    logic                                 sdram_ready;
    logic                                 sdram_write;
    logic [SDRAM_ADDR_W-1:0]              sdram_address;
    logic [STRB_W-1:0]                    sdram_wstrb;
    logic [DATA_W-1:0]                    sdram_wdata;
    logic                                 sdram_rvalid;
    logic [DATA_W-1:0]                    sdram_rdata;
    logic [TAG_W-1:0]                     sdram_rtag;

    modport master (
        output req_request, req_lock, req_write, req_address, req_wstrb, req_wdata,
        input  req_ready, req_rvalid, req_rdata, req_rtag,
        input  sdram_request, sdram_write, sdram_address, sdram_wstrb, sdram_wdata,
        output sdram_ready, sdram_rvalid, sdram_rdata, sdram_rtag
    );

    modport slave (
        input  req_request, req_lock, req_write, req_address, req_wstrb, req_wdata,
        output req_ready, req_rvalid, req_rdata, req_rtag,
        output sdram_request, sdram_write, sdram_address, sdram_wstrb, sdram_wdata,
        input  sdram_ready, sdram_rvalid, sdram_rdata, sdram_rtag
    );

endinterface
`default_nettype wire

// File: rtl/cpu_sdram_arbiter_owner_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sdram_arb_owner_fifo
// Brief    : In-order FIFO of requester indices owning outstanding reads.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_sdram_arb_owner_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 2
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              i_push,
    input  wire logic [DATA_W-1:0] i_push_data,
    input  wire logic              i_pop,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [DATA_W-1:0]      o_head
);
    localparam int c_PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == (c_PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sdram_arbiter
// Brief    : Round-robin SDRAM port arbiter with burst locking and read-owner
//            routing. SDRAM_ARB_PRIO_EN gives the dcache strict priority in IDLE.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_sdram_arbiter
    import cpu_sdram_arb_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int OUTSTANDING = 8,
    parameter int MAX_BURST   = 8
) (
    input  wire logic            clock,
    input  wire logic            reset,      // active low, asynchronous
    cpu_sdram_arbiter_if.slave   bus,
    output logic                 arb_orphan
);
    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t         r_state;
    logic [c_IDX_W-1:0] r_rr_ptr;
    logic [c_IDX_W-1:0] r_lock_owner;
    logic [c_CNT_W-1:0] r_burst_cnt;
    logic               r_orphan;

    logic               w_gnt_valid;
    logic [c_IDX_W-1:0] w_gnt_idx;
    logic [c_IDX_W-1:0] w_next_ptr;
    logic               w_sel_write;
    logic               w_sel_lock;
    logic               w_drive;
    logic               w_accept;
    logic               w_burst_last;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [c_IDX_W-1:0] w_fifo_head;
    logic               w_rsp_routed;

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        if (r_state == LOCKED) begin
            // Owner keeps the port even while it pauses its requests
            w_gnt_idx   = r_lock_owner;
            w_gnt_valid = bus.req_request[r_lock_owner];
        end else begin
`ifdef SDRAM_ARB_PRIO_EN
            if (bus.req_request[REQ_DCACHE]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = c_IDX_W'(REQ_DCACHE);
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!w_gnt_valid && (((int'(r_rr_ptr) + k) % NUM_REQ) != REQ_DCACHE)
                    && bus.req_request[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                    w_gnt_valid = 1'b1;
                    w_gnt_idx   = c_IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
                end
            end
`else
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!w_gnt_valid && bus.req_request[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                    w_gnt_valid = 1'b1;
                    w_gnt_idx   = c_IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
                end
            end
`endif
        end
    end

    assign w_sel_write  = bus.req_write[w_gnt_idx];
    assign w_sel_lock   = bus.req_lock[w_gnt_idx];
    assign w_drive      = reset & w_gnt_valid;
    assign w_next_ptr   = (w_gnt_idx == c_IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_burst_last = (int'(r_burst_cnt) + 1 >= MAX_BURST);

    // A full owner FIFO blocks reads even on a popping cycle; writes pass
    assign bus.sdram_request = w_drive & ~(~w_sel_write & w_fifo_full);
    assign w_accept          = bus.sdram_request & bus.sdram_ready;
    assign bus.sdram_write   = w_drive & w_sel_write;
    assign bus.sdram_address = w_drive ? bus.req_address[w_gnt_idx] : '0;
    assign bus.sdram_wstrb   = w_drive ? bus.req_wstrb[w_gnt_idx]   : '0;
    assign bus.sdram_wdata   = w_drive ? bus.req_wdata[w_gnt_idx]   : '0;

    assign w_rsp_routed  = reset & bus.sdram_rvalid & ~w_fifo_empty;
    assign bus.req_rdata = reset ? bus.sdram_rdata : '0;
    assign bus.req_rtag  = reset ? bus.sdram_rtag  : '0;
    assign arb_orphan    = r_orphan;

    always_comb begin
        bus.req_ready  = '0;
        bus.req_rvalid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i]  = w_accept && (w_gnt_idx == c_IDX_W'(i));
            bus.req_rvalid[i] = w_rsp_routed && (w_fifo_head == c_IDX_W'(i));
        end
    end

    cpu_sdram_arb_owner_fifo #(
        .DEPTH  (OUTSTANDING),
        .DATA_W (c_IDX_W)
    ) u_owner_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (w_accept & ~w_sel_write),
        .i_push_data (w_gnt_idx),
        .i_pop       (w_rsp_routed),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_head      (w_fifo_head)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_lock_owner <= '0;
            r_burst_cnt  <= '0;
            r_orphan     <= 1'b0;
        end else begin
            r_orphan <= bus.sdram_rvalid & w_fifo_empty;
            if (w_accept) begin
                case (r_state)
                    IDLE: begin
                        if (w_sel_lock && MAX_BURST > 1) begin
                            r_state      <= LOCKED;
                            r_lock_owner <= w_gnt_idx;
                            r_burst_cnt  <= c_CNT_W'(1);
                        end else begin
                            r_rr_ptr <= w_next_ptr;
                        end
                    end
                    LOCKED: begin
                        if (!w_sel_lock || w_burst_last) begin
                            r_state     <= IDLE;
                            r_burst_cnt <= '0;
                            r_rr_ptr    <= w_next_ptr;
                        end else begin
                            r_burst_cnt <= r_burst_cnt + 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_sdram_arbiter
// Brief    : Directed self-checking bench for the CPU SDRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_sdram_arbiter;
    import cpu_sdram_arb_pkg::*;

    localparam int NR = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic arb_orphan;
    int   n_checks = 0;
    int   n_errors = 0;

    cpu_sdram_arbiter_if #(.NUM_REQ(NR)) bus ();

    cpu_sdram_arbiter #(
        .NUM_REQ     (NR),
        .OUTSTANDING (8),
        .MAX_BURST   (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .arb_orphan (arb_orphan)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic rq, input logic lk, input logic wr);
        bus.req_request[i] = rq;
        bus.req_lock[i]    = lk;
        bus.req_write[i]   = wr;
    endtask

    task automatic idle_all();
        bus.req_request  = '0;
        bus.req_lock     = '0;
        bus.req_write    = '0;
        bus.sdram_rvalid = 1'b0;
    endtask

    // Check the grant vector for the current inputs, then let the edge accept it
    task automatic beat(input string tag, input logic [NR-1:0] exp_ready);
        #1;
        check(tag, 64'(bus.req_ready), 64'(exp_ready));
        cyc();
    endtask

    task automatic rsp(input string tag, input logic [NR-1:0] exp_rv,
                       input logic [31:0] d, input logic [8:0] t);
        bus.sdram_rvalid = 1'b1;
        bus.sdram_rdata  = d;
        bus.sdram_rtag   = t;
        #1;
        check({tag, "_rv"},   64'(bus.req_rvalid), 64'(exp_rv));
        check({tag, "_data"}, 64'(bus.req_rdata),  64'(d));
        check({tag, "_tag"},  64'(bus.req_rtag),   64'(t));
        cyc();
        bus.sdram_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        idle_all();
        bus.sdram_ready = 1'b1;
        bus.sdram_rdata = '0;
        bus.sdram_rtag  = '0;
        for (int i = 0; i < NR; i++) begin
            bus.req_address[i] = 26'(32'h100 * (i + 1));
            bus.req_wdata[i]   = 32'hA000_0000 | 32'(i);
            bus.req_wstrb[i]   = 4'(i + 1);
        end

        // Reset: outputs forced low even with a live request
        #2 reset = 1'b0;
        set_req(0, 1'b1, 1'b0, 1'b1);
        #3;
        check("rst_sdram_request", 64'(bus.sdram_request), 64'd0);
        check("rst_req_ready",     64'(bus.req_ready),     64'd0);
        check("rst_sdram_address", 64'(bus.sdram_address), 64'd0);
        check("rst_orphan",        64'(arb_orphan),        64'd0);
        idle_all();
        #5 reset = 1'b1;
        cyc();

        // 1: alternating single reads from 0 and 1
        set_req(0, 1'b1, 1'b0, 1'b0);
        set_req(1, 1'b1, 1'b0, 1'b0);
        #1;
        check("t1_addr0", 64'(bus.sdram_address), 64'h100);
        check("t1_wr0",   64'(bus.sdram_write),   64'd0);
        beat("t1_g0", 3'b001);
        #1;
        check("t1_addr1", 64'(bus.sdram_address), 64'h200);
        beat("t1_g1", 3'b010);
        beat("t1_g2", 3'b001);
        beat("t1_g3", 3'b010);
        idle_all();
        rsp("t1_r0", 3'b001, 32'h1111_0001, 9'h011);
        rsp("t1_r1", 3'b010, 32'h1111_0002, 9'h012);
        rsp("t1_r2", 3'b001, 32'h1111_0003, 9'h013);
        rsp("t1_r3", 3'b010, 32'h1111_0004, 9'h014);

        // 2: 4-beat locked read from 1 while 0 waits
        set_req(1, 1'b1, 1'b1, 1'b0);
        beat("t2_b1", 3'b010);
        set_req(0, 1'b1, 1'b0, 1'b0);
        beat("t2_b2", 3'b010);
        beat("t2_b3", 3'b010);
        set_req(1, 1'b1, 1'b0, 1'b0);
        beat("t2_b4", 3'b010);
        set_req(1, 1'b0, 1'b0, 1'b0);
        beat("t2_b5", 3'b001);
        idle_all();
        rsp("t2_r0", 3'b010, 32'h2222_0001, 9'h021);
        rsp("t2_r1", 3'b010, 32'h2222_0002, 9'h022);
        rsp("t2_r2", 3'b010, 32'h2222_0003, 9'h023);
        rsp("t2_r3", 3'b010, 32'h2222_0004, 9'h024);
        rsp("t2_r4", 3'b001, 32'h2222_0005, 9'h025);

        // 3: locked writes from 2 exceed MAX_BURST; owner pause keeps the lock
        set_req(2, 1'b1, 1'b1, 1'b1);
        beat("t3_b1", 3'b100);
        set_req(0, 1'b1, 1'b0, 1'b1);
        #1;
        check("t3_addr2",  64'(bus.sdram_address), 64'h300);
        check("t3_wr2",    64'(bus.sdram_write),   64'd1);
        check("t3_wdata2", 64'(bus.sdram_wdata),   64'hA000_0002);
        check("t3_wstrb2", 64'(bus.sdram_wstrb),   64'h3);
        beat("t3_b2", 3'b100);
        beat("t3_b3", 3'b100);
        set_req(2, 1'b0, 1'b1, 1'b1);
        #1;
        check("t3_pause_req",   64'(bus.sdram_request), 64'd0);
        check("t3_pause_ready", 64'(bus.req_ready),     64'd0);
        cyc();
        set_req(2, 1'b1, 1'b1, 1'b1);
        for (int b = 4; b <= 8; b++) beat($sformatf("t3_b%0d", b), 3'b100);
        beat("t3_release", 3'b001);
        idle_all();

        // 4: eight reads fill the FIFO; a write still passes; a pop unblocks
        set_req(1, 1'b1, 1'b0, 1'b0);
        for (int b = 0; b < 8; b++) beat($sformatf("t4_fill%0d", b), 3'b010);
        #1;
        check("t4_full_req",   64'(bus.sdram_request), 64'd0);
        check("t4_full_ready", 64'(bus.req_ready),     64'd0);
        cyc();
        set_req(2, 1'b1, 1'b0, 1'b1);
        beat("t4_write", 3'b100);
        set_req(2, 1'b0, 1'b0, 1'b0);
        bus.sdram_rvalid = 1'b1;
        bus.sdram_rdata  = 32'h4444_0000;
        bus.sdram_rtag   = 9'h040;
        #1;
        check("t4_pop_req", 64'(bus.sdram_request), 64'd0);
        check("t4_pop_rv",  64'(bus.req_rvalid),    64'(3'b010));
        cyc();
        bus.sdram_rvalid = 1'b0;
        beat("t4_unblock", 3'b010);
        idle_all();
        for (int b = 0; b < 8; b++)
            rsp($sformatf("t4_drain%0d", b), 3'b010, 32'h4444_0001 + 32'(b), 9'(b));

        // 5: orphan response, then reset during a locked burst
        bus.sdram_rvalid = 1'b1;
        bus.sdram_rtag   = 9'h1A5;
        bus.sdram_rdata  = 32'h5555_5555;
        #1;
        check("t5_orphan_rv",  64'(bus.req_rvalid), 64'd0);
        check("t5_orphan_tag", 64'(bus.req_rtag),   64'h1A5);
        check("t5_orphan_pre", 64'(arb_orphan),     64'd0);
        cyc();
        bus.sdram_rvalid = 1'b0;
        check("t5_orphan_pulse", 64'(arb_orphan), 64'd1);
        cyc();
        check("t5_orphan_clear", 64'(arb_orphan), 64'd0);
        set_req(1, 1'b1, 1'b1, 1'b0);
        beat("t5_lb1", 3'b010);
        beat("t5_lb2", 3'b010);
        beat("t5_lb3", 3'b010);
        set_req(0, 1'b1, 1'b0, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("t5_rst_req",   64'(bus.sdram_request), 64'd0);
        check("t5_rst_ready", 64'(bus.req_ready),     64'd0);
        check("t5_rst_addr",  64'(bus.sdram_address), 64'd0);
        cyc();
        #2 reset = 1'b1;
        set_req(1, 1'b1, 1'b0, 1'b0);
        beat("t5_after_rst", 3'b001);
        idle_all();
        bus.sdram_rvalid = 1'b1;
        bus.sdram_rtag   = 9'h0AB;
        #1;
        check("t5_lost_rv", 64'(bus.req_rvalid), 64'd0);
        cyc();
        bus.sdram_rvalid = 1'b0;
        check("t5_lost_orphan", 64'(arb_orphan), 64'd1);

        // 6: requesters 0 and 2 writing continuously
        set_req(0, 1'b1, 1'b0, 1'b1);
        set_req(2, 1'b1, 1'b0, 1'b1);
`ifdef SDRAM_ARB_PRIO_EN
        beat("t6_g0", 3'b001);
        beat("t6_g1", 3'b001);
        beat("t6_g2", 3'b001);
`else
        beat("t6_g0", 3'b100);
        beat("t6_g1", 3'b001);
        beat("t6_g2", 3'b100);
`endif
        set_req(0, 1'b0, 1'b0, 1'b0);
        beat("t6_g3", 3'b100);
        idle_all();
        cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
